// File: rtl/decompressor_if.sv
// Purpose : bundles the decompressor's control, byte-RAM read and coefficient-RAM write signals.
// Latency : none (wires only).
// Backpressure: none; the decompressor reads and writes on a fixed schedule.
// Ports   : start/done control, byte_addr/byte_do read port, poly_addra/poly_dia/poly_wea write port,
//           busy when DECOMP_BUSY_EN is defined.
// master = the decompressor; slave = the environment (RAMs and controller).
interface decompressor_if;
    logic        start;
    logic        done;
    logic [7:0]  byte_addr;
    logic [7:0]  byte_do;
    logic [8:0]  poly_addra;
    logic [15:0] poly_dia;
    logic        poly_wea;
`ifdef DECOMP_BUSY_EN
    logic        busy;
`endif

    modport master (
        input  start,
        input  byte_do,
        output done,
        output byte_addr,
        output poly_addra,
        output poly_dia,
        output poly_wea
`ifdef DECOMP_BUSY_EN
        ,
        output busy
`endif
    );

    modport slave (
        output start,
        output byte_do,
        input  done,
        input  byte_addr,
        input  poly_addra,
        input  poly_dia,
        input  poly_wea
`ifdef DECOMP_BUSY_EN
        ,
        input  busy
`endif
    );
endinterface

// File: rtl/decompressor.sv
// Purpose : unpacks 64 groups of 3 bytes into 512 3-bit fields and writes each field's 16-bit coefficient.
// Latency : 12 cycles per group; with start sampled at cycle 0, done pulses at cycle 769.
// Backpressure: none; start is ignored while a run is in progress.
// Ports   : clk, rst (synchronous, active-high), bus (decompressor_if.master):
//           start in, done out, byte_addr out / byte_do in (1-cycle read latency),
//           poly_addra/poly_dia/poly_wea out, busy out only when DECOMP_BUSY_EN is defined.
// Optional feature macro: DECOMP_BUSY_EN adds the registered busy output.
module decompressor (
    input  logic           clk,
    input  logic           rst,
    decompressor_if.master bus
);

    typedef enum logic [2:0] {
        HOLD = 3'd0,
        RD0  = 3'd1,
        RD1  = 3'd2,
        RD2  = 3'd3,
        RD3  = 3'd4,
        WR   = 3'd5,
        FIN  = 3'd6
    } state_t;

    state_t      state, state_nxt;
    logic [5:0]  g, g_nxt;
    logic [2:0]  j, j_nxt;
    logic [7:0]  b0, b1, b2;

    logic        done_q;
    logic        wea_q;
    logic [7:0]  byte_addr_q;
    logic [8:0]  poly_addra_q;
    logic [15:0] poly_dia_q;

    logic [7:0]  base3;
    logic [7:0]  addr_nxt;
    logic [2:0]  field_nxt;
    logic [15:0] coef_nxt;

    // (x*12289 + 4) >> 3 for each 3-bit field value.
    function automatic logic [15:0] coef_of(input logic [2:0] x);
        logic [15:0] c;
        case (x)
            3'd0:    c = 16'd0;
            3'd1:    c = 16'd1536;
            3'd2:    c = 16'd3072;
            3'd3:    c = 16'd4608;
            3'd4:    c = 16'd6145;
            3'd5:    c = 16'd7681;
            3'd6:    c = 16'd9217;
            default: c = 16'd10753;
        endcase
        return c;
    endfunction

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        g_nxt     = g;
        j_nxt     = j;
        case (state)
            HOLD: begin
                if (bus.start) begin
                    state_nxt = RD0;
                    g_nxt     = 6'd0;
                    j_nxt     = 3'd0;
                end
            end
            RD0: state_nxt = RD1;
            RD1: state_nxt = RD2;
            RD2: state_nxt = RD3;
            RD3: begin
                state_nxt = WR;
                j_nxt     = 3'd0;
            end
            WR: begin
                if (j == 3'd7) begin
                    j_nxt = 3'd0;
                    if (g == 6'd63) begin
                        state_nxt = FIN;
                    end else begin
                        state_nxt = RD0;
                        g_nxt     = g + 6'd1;
                    end
                end else begin
                    j_nxt = j + 3'd1;
                end
            end
            FIN: begin
                state_nxt = HOLD;
                g_nxt     = 6'd0;
            end
            default: state_nxt = HOLD;
        endcase
    end

    // Outputs are registered, so they are computed from the state being entered.
    // The group's 24 bits pack the fields little-endian: field j is bits [3j+2:3j] of {b2,b1,b0}.
    // Entering WR with j=0 happens on the same edge that captures b2, which is fine because
    // field 0 lies entirely in b0; fields using b2 (j>=5) are formed well after it is captured.
    always_comb begin
        base3    = {1'b0, g_nxt, 1'b0} + {2'b00, g_nxt};
        addr_nxt = base3;
        if (state_nxt == RD1) begin
            addr_nxt = base3 + 8'd1;
        end else if (state_nxt == RD2) begin
            addr_nxt = base3 + 8'd2;
        end

        field_nxt = b0[2:0];
        case (j_nxt)
            3'd0:    field_nxt = b0[2:0];
            3'd1:    field_nxt = b0[5:3];
            3'd2:    field_nxt = {b1[0], b0[7:6]};
            3'd3:    field_nxt = b1[3:1];
            3'd4:    field_nxt = b1[6:4];
            3'd5:    field_nxt = {b2[1:0], b1[7]};
            3'd6:    field_nxt = b2[4:2];
            default: field_nxt = b2[7:5];
        endcase
        coef_nxt = coef_of(field_nxt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= HOLD;
            g            <= 6'd0;
            j            <= 3'd0;
            b0           <= 8'd0;
            b1           <= 8'd0;
            b2           <= 8'd0;
            done_q       <= 1'b0;
            wea_q        <= 1'b0;
            byte_addr_q  <= 8'd0;
            poly_addra_q <= 9'd0;
            poly_dia_q   <= 16'd0;
        end else begin
            state <= state_nxt;
            g     <= g_nxt;
            j     <= j_nxt;

            // Read data arrives one cycle after its address was presented.
            if (state == RD1) b0 <= bus.byte_do;
            if (state == RD2) b1 <= bus.byte_do;
            if (state == RD3) b2 <= bus.byte_do;

            done_q <= (state_nxt == FIN);
            wea_q  <= (state_nxt == WR);

            if (state_nxt == RD0 || state_nxt == RD1 || state_nxt == RD2) begin
                byte_addr_q <= addr_nxt;
            end
            if (state_nxt == WR) begin
                poly_addra_q <= {g_nxt, j_nxt};
                poly_dia_q   <= coef_nxt;
            end
        end
    end

    assign bus.done       = done_q;
    assign bus.poly_wea   = wea_q;
    assign bus.byte_addr  = byte_addr_q;
    assign bus.poly_addra = poly_addra_q;
    assign bus.poly_dia   = poly_dia_q;

`ifdef DECOMP_BUSY_EN
    logic busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= (state_nxt != HOLD);
        end
    end

    assign bus.busy = busy_q;
`endif

endmodule

// File: tb/tb_decompressor.sv
module tb_decompressor;

    logic clk = 1'b0;
    logic rst = 1'b1;

    decompressor_if bus ();

    decompressor dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Compressed-byte RAM with one cycle of read latency.
    logic [7:0] mem [0:255];
    always @(posedge clk) bus.byte_do <= mem[bus.byte_addr];

    int total = 0;
    int bad   = 0;

    // Observations from the most recent run.
    logic [8:0]  wr_a [$];
    logic [15:0] wr_d [$];
    int          wr_c [$];
    int          done_c [$];
    int          busy_err;
    int          max_ba;
    logic [7:0]  first_ba;
    logic [7:0]  snap_ba;
    logic [8:0]  snap_pa;
    logic [15:0] snap_pd;

    int          exp_coef [0:511];

    function automatic int map3(input int x);
        return (x * 12289 + 4) >> 3;
    endfunction

    function automatic int compress3(input int c);
        return ((c * 8 + 6144) / 12289) % 8;
    endfunction

    // Coefficient k from the RAM contents, reading the 3-bit fields as a little-endian bit stream.
    function automatic int model_coef(input int k);
        int word;
        int x;
        word = int'(mem[3*(k/8)]) | (int'(mem[3*(k/8)+1]) << 8) | (int'(mem[3*(k/8)+2]) << 16);
        x = (word >> (3 * (k % 8))) & 7;
        return map3(x);
    endfunction

    // Cycle of the k-th write when start is sampled at cycle 0: 4 read cycles then 8 writes per group.
    function automatic int write_cycle(input int k);
        return 12 * (k / 8) + 5 + (k % 8);
    endfunction

    // Pulses start into HOLD and records writes/done for 820 cycles. rst_at>0 asserts rst at
    // that cycle for three cycles; spam toggles start randomly while the run is active.
    task automatic run_op(input int rst_at, input bit spam);
        bit exp_busy;
        wr_a.delete(); wr_d.delete(); wr_c.delete(); done_c.delete();
        busy_err = 0;
        max_ba   = 0;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 820; c++) begin
            @(negedge clk);
            if (bus.poly_wea === 1'b1) begin
                wr_a.push_back(bus.poly_addra);
                wr_d.push_back(bus.poly_dia);
                wr_c.push_back(c);
            end
            if (bus.done === 1'b1) done_c.push_back(c);
            if (int'(bus.byte_addr) > max_ba) max_ba = int'(bus.byte_addr);
            if (c == 1) first_ba = bus.byte_addr;
            if (rst_at > 0 && c == rst_at + 2) begin
                snap_ba = bus.byte_addr;
                snap_pa = bus.poly_addra;
                snap_pd = bus.poly_dia;
            end
            exp_busy = (c <= 769) && (rst_at == 0 || c <= rst_at);
`ifdef DECOMP_BUSY_EN
            if (bus.busy !== exp_busy) busy_err++;
`else
            if (exp_busy && bus.done === 1'b1 && c != 769) busy_err++;
`endif
            bus.start = (spam && c < 769) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (rst_at > 0 && c == rst_at) rst = 1'b1;
            if (rst_at > 0 && c == rst_at + 3) rst = 1'b0;
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
        total++; if (bus.poly_wea !== 1'b0) begin bad++; $display("FAIL reset_wea: got %b want 0", bus.poly_wea); end
        total++; if (bus.byte_addr !== 8'd0) begin bad++; $display("FAIL reset_byte_addr: got %0d want 0", bus.byte_addr); end
        total++; if (bus.poly_addra !== 9'd0) begin bad++; $display("FAIL reset_poly_addra: got %0d want 0", bus.poly_addra); end
        total++; if (bus.poly_dia !== 16'd0) begin bad++; $display("FAIL reset_poly_dia: got %0d want 0", bus.poly_dia); end
`ifdef DECOMP_BUSY_EN
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_all_zero();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        run_op(0, 1'b0);
        total++; if (wr_a.size() != 512) begin bad++; $display("FAIL zero_count: got %0d want 512", wr_a.size()); end
        for (int k = 0; k < wr_a.size() && k < 512; k++) begin
            total++;
            if (wr_a[k] !== 9'(k) || wr_d[k] !== 16'd0 || wr_c[k] != write_cycle(k)) begin
                bad++;
                $display("FAIL zero_write[%0d]: got addr=%0d data=%0d cycle=%0d want addr=%0d data=0 cycle=%0d",
                         k, wr_a[k], wr_d[k], wr_c[k], k, write_cycle(k));
            end
        end
        total++;
        if (done_c.size() != 1 || done_c[0] != 769) begin
            bad++;
            $display("FAIL zero_done: got %0d pulses first=%0d want 1 pulse at 769",
                     done_c.size(), (done_c.size() > 0) ? done_c[0] : -1);
        end
        total++; if (max_ba != 191) begin bad++; $display("FAIL zero_max_byte_addr: got %0d want 191", max_ba); end
        total++; if (first_ba !== 8'd0) begin bad++; $display("FAIL zero_first_byte_addr: got %0d want 0", first_ba); end
`ifdef DECOMP_BUSY_EN
        total++; if (busy_err != 0) begin bad++; $display("FAIL zero_busy: got %0d wrong cycles want 0", busy_err); end
`endif
    endtask

    task automatic test_all_ff();
        for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
        run_op(0, 1'b0);
        total++; if (wr_a.size() != 512) begin bad++; $display("FAIL ff_count: got %0d want 512", wr_a.size()); end
        for (int k = 0; k < wr_a.size() && k < 512; k++) begin
            total++;
            if (wr_a[k] !== 9'(k) || wr_d[k] !== 16'd10753) begin
                bad++;
                $display("FAIL ff_write[%0d]: got addr=%0d data=%0d want addr=%0d data=10753", k, wr_a[k], wr_d[k], k);
            end
        end
        total++;
        if (done_c.size() != 1 || done_c[0] != 769) begin
            bad++;
            $display("FAIL ff_done: got %0d pulses first=%0d want 1 pulse at 769",
                     done_c.size(), (done_c.size() > 0) ? done_c[0] : -1);
        end
    endtask

    task automatic test_group0_pattern();
        int want [0:7];
        want = '{0, 1536, 3072, 4608, 6145, 7681, 9217, 10753};
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h88; mem[1] = 8'hC6; mem[2] = 8'hFA;
        run_op(0, 1'b0);
        total++; if (wr_a.size() != 512) begin bad++; $display("FAIL pat_count: got %0d want 512", wr_a.size()); end
        for (int k = 0; k < 8 && k < wr_a.size(); k++) begin
            total++;
            if (wr_a[k] !== 9'(k) || wr_d[k] !== 16'(want[k])) begin
                bad++;
                $display("FAIL pat_write[%0d]: got addr=%0d data=%0d want addr=%0d data=%0d", k, wr_a[k], wr_d[k], k, want[k]);
            end
        end
        for (int k = 8; k < wr_a.size() && k < 512; k++) begin
            total++;
            if (wr_d[k] !== 16'(model_coef(k))) begin
                bad++;
                $display("FAIL pat_rand_write[%0d]: got %0d want %0d", k, wr_d[k], model_coef(k));
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int n_exp;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        n_exp = 0;
        for (int k = 0; k < 512; k++) if (write_cycle(k) <= 300) n_exp++;
        run_op(300, 1'b0);
        total++; if (wr_a.size() != n_exp) begin bad++; $display("FAIL rst_mid_count: got %0d want %0d", wr_a.size(), n_exp); end
        for (int k = 0; k < wr_a.size(); k++) begin
            total++;
            if (wr_c[k] > 300 || wr_a[k] !== 9'(k) || wr_d[k] !== 16'(model_coef(k))) begin
                bad++;
                $display("FAIL rst_mid_write[%0d]: got addr=%0d data=%0d cycle=%0d want addr=%0d data=%0d cycle<=300",
                         k, wr_a[k], wr_d[k], wr_c[k], k, model_coef(k));
            end
        end
        total++; if (done_c.size() != 0) begin bad++; $display("FAIL rst_mid_done: got %0d pulses want 0", done_c.size()); end
        total++;
        if (snap_ba !== 8'd0 || snap_pa !== 9'd0 || snap_pd !== 16'd0) begin
            bad++;
            $display("FAIL rst_mid_outputs: got byte_addr=%0d poly_addra=%0d poly_dia=%0d want 0 0 0", snap_ba, snap_pa, snap_pd);
        end
`ifdef DECOMP_BUSY_EN
        total++; if (busy_err != 0) begin bad++; $display("FAIL rst_mid_busy: got %0d wrong cycles want 0", busy_err); end
`endif
        // A fresh start after the abort runs to completion from group 0.
        run_op(0, 1'b0);
        total++; if (wr_a.size() != 512) begin bad++; $display("FAIL rst_again_count: got %0d want 512", wr_a.size()); end
        total++;
        if (wr_a.size() > 0 && (wr_a[0] !== 9'd0 || wr_d[0] !== 16'(model_coef(0)))) begin
            bad++;
            $display("FAIL rst_again_first: got addr=%0d data=%0d want addr=0 data=%0d", wr_a[0], wr_d[0], model_coef(0));
        end
        total++;
        if (done_c.size() != 1 || done_c[0] != 769) begin
            bad++;
            $display("FAIL rst_again_done: got %0d pulses first=%0d want 1 pulse at 769",
                     done_c.size(), (done_c.size() > 0) ? done_c[0] : -1);
        end
    endtask

    task automatic test_start_spam();
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        run_op(0, 1'b1);
        total++; if (wr_a.size() != 512) begin bad++; $display("FAIL spam_count: got %0d want 512", wr_a.size()); end
        for (int k = 0; k < wr_a.size() && k < 512; k++) begin
            total++;
            if (wr_a[k] !== 9'(k) || wr_d[k] !== 16'(model_coef(k)) || wr_c[k] != write_cycle(k)) begin
                bad++;
                $display("FAIL spam_write[%0d]: got addr=%0d data=%0d cycle=%0d want addr=%0d data=%0d cycle=%0d",
                         k, wr_a[k], wr_d[k], wr_c[k], k, model_coef(k), write_cycle(k));
            end
        end
        total++;
        if (done_c.size() != 1 || done_c[0] != 769) begin
            bad++;
            $display("FAIL spam_done: got %0d pulses first=%0d want 1 pulse at 769",
                     done_c.size(), (done_c.size() > 0) ? done_c[0] : -1);
        end
    endtask

    task automatic test_round_trip();
        logic [1535:0] bits;
        int comp;
        for (int k = 0; k < 512; k++) begin
            comp = compress3(int'($urandom_range(0, 12288)));
            exp_coef[k] = map3(comp);
            for (int b = 0; b < 3; b++) bits[3*k+b] = 1'((comp >> b) & 1);
        end
        for (int i = 0; i < 192; i++) mem[i] = bits[8*i +: 8];
        run_op(0, 1'b0);
        total++; if (wr_a.size() != 512) begin bad++; $display("FAIL rt_count: got %0d want 512", wr_a.size()); end
        for (int k = 0; k < wr_a.size() && k < 512; k++) begin
            total++;
            if (wr_a[k] !== 9'(k) || wr_d[k] !== 16'(exp_coef[k]) || wr_d[k][15:14] !== 2'b00) begin
                bad++;
                $display("FAIL rt_write[%0d]: got addr=%0d data=%0d want addr=%0d data=%0d", k, wr_a[k], wr_d[k], k, exp_coef[k]);
            end
        end
`ifdef DECOMP_BUSY_EN
        total++; if (busy_err != 0) begin bad++; $display("FAIL rt_busy: got %0d wrong cycles want 0", busy_err); end
`endif
    endtask

    task automatic test_reset_priority();
        int n_wr;
        int n_done;
        int first_wr;
        int done_at;
        // rst and start together: nothing may start.
        @(negedge clk);
        rst = 1'b1; bus.start = 1'b1;
        @(negedge clk);
        rst = 1'b0; bus.start = 1'b0;
        n_wr = 0; n_done = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.poly_wea !== 1'b0) n_wr++;
            if (bus.done !== 1'b0) n_done++;
        end
        total++; if (n_wr != 0 || n_done != 0) begin bad++; $display("FAIL prio_idle: got writes=%0d done=%0d want 0 0", n_wr, n_done); end
        // start held across rst release is honoured on the first cycle after release.
        rst = 1'b1; bus.start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        first_wr = -1; done_at = -1;
        for (int c = 1; c <= 800; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (first_wr < 0 && bus.poly_wea === 1'b1) first_wr = c;
            if (done_at < 0 && bus.done === 1'b1) done_at = c;
        end
        total++; if (first_wr != 5) begin bad++; $display("FAIL prio_first_write: got cycle %0d want 5", first_wr); end
        total++; if (done_at != 769) begin bad++; $display("FAIL prio_done: got cycle %0d want 769", done_at); end
    endtask

    initial begin
        bus.start = 1'b0;
        test_reset();
        test_all_zero();
        test_all_ff();
        test_group0_pattern();
        test_reset_mid_run();
        test_start_spam();
        test_round_trip();
        test_reset_priority();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decompressor.md
DECOMPRESSOR -- requirements
Module: decompressor

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-002 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-003 SHALL have port start, input, 1; a request to begin decompression, sampled only in HOLD.
REQ-004 SHALL have port done, output, 1; a one-cycle completion pulse, registered.
REQ-005 SHALL have port byte_addr, output, 8; the compressed-byte RAM read address, registered.
REQ-006 SHALL have port byte_do, input, 8; the RAM read data, valid one cycle after byte_addr changes.
REQ-007 SHALL have port poly_addra, output, 9; the coefficient RAM write address, registered.
REQ-008 SHALL have port poly_dia, output, 16; the coefficient write data, registered.
REQ-009 SHALL have port poly_wea, output, 1; the coefficient write enable, registered.
REQ-010 SHALL have port busy, output, 1, present only with DECOMP_BUSY_EN; it is high in any state other than HOLD.

Function
REQ-011 SHALL decode 64 groups, g = 0..63; each group is 3 bytes at byte addresses 3g, 3g+1, 3g+2 and produces 8 coefficients at poly addresses 8g+0 .. 8g+7.
REQ-012 SHALL unpack the 3-bit fields as follows:
- t0 = b0[2:0], t1 = b0[5:3], t2 = {b1[0], b0[7:6]}
- t3 = b1[3:1], t4 = b1[6:4], t5 = {b2[1:0], b1[7]}
- t6 = b2[4:2], t7 = b2[7:5]
REQ-013 SHALL map each field x to (x*12289 + 4) >> 3 using a constant table: 0, 1536, 3072, 4608, 6145, 7681, 9217, 10753.
REQ-014 SHALL have states HOLD, RD0, RD1, RD2, RD3, WR and FIN.
- HOLD goes to RD0 on start; otherwise it stays in HOLD.
- RD0 -> RD1 -> RD2 -> RD3 -> WR.
- WR lasts 8 cycles (j = 0..7), then goes to RD0 if g < 63, else to FIN.
- FIN goes to HOLD.
REQ-015 SHALL drive the read addresses as follows:
- byte_addr = 3g in RD0, 3g+1 in RD1, 3g+2 in RD2.
- byte_do is captured as b0 in RD1, b1 in RD2 and b2 in RD3.
REQ-016 SHALL, in WR cycle j, have poly_wea = 1, poly_addra = {g[5:0], j[2:0]} and poly_dia = the map of tj.
REQ-017 SHALL hold poly_wea at 0 in every state other than WR.
REQ-018 SHALL take exactly 12 cycles per group; with start sampled at cycle 0, done is high at cycle 769 only.
REQ-019 SHALL ignore start outside HOLD; a new start in HOLD restarts at g = 0 and byte_addr = 0.
REQ-020 SHALL never let byte_addr exceed 191, nor poly_addra exceed 511; no wrap-around occurs.
REQ-021 SHALL keep all 16-bit outputs zero-extended; bits [15:14] of poly_dia are always 0.

Reset
REQ-022 SHALL, while rst is high, force state = HOLD, g = 0, j = 0, done = 0, poly_wea = 0, byte_addr = 0, poly_addra = 0, poly_dia = 0 (and busy = 0 if present).
REQ-023 SHALL let rst mid-operation abort the operation on the next edge, with no further writes and no done pulse.
REQ-024 SHALL give rst priority over a simultaneous start; start is honoured only from the first cycle after rst deasserts.

Configuration
REQ-025 SHALL compile the busy port and its logic in when macro DECOMP_BUSY_EN is defined; busy is registered and high from the cycle after start is accepted through FIN inclusive.
REQ-026 SHALL omit the busy port when DECOMP_BUSY_EN is undefined; all other behaviour is identical, cycle for cycle.

Verification
REQ-027 SHALL cover all-zero bytes: start -> 512 writes of 0, addresses 0..511 ascending, done at cycle 769.
REQ-028 SHALL cover all-0xFF bytes: start -> all 512 writes of 10753.
REQ-029 SHALL cover group 0 bytes 0x88, 0xC6, 0xFA: group 0 writes, in order, 0, 1536, 3072, 4608, 6145, 7681, 9217, 10753.
REQ-030 SHALL cover reset mid-run: rst at cycle 300 -> poly_wea = 0 and done = 0 thereafter; a second start completes normally in 769 cycles.
REQ-031 SHALL cover start pulsed repeatedly during a run: no restart, and exactly one done pulse.
REQ-032 SHALL cover round-trip: random 512 coefficients, then compressor, then decompressor; each result matches the map of the compressed 3-bit value, and with DECOMP_BUSY_EN busy is high for cycles 1..769.
